lcd_fill_rect: RTL and testbench
================================

Name: lcd_fill_rect

Overview:
- Rectangle-fill engine for the ST7735 128x128 panel.
- Takes a window (x0,y0,x1,y1) and a 16-bit RGB565 colour, then emits the CASET/RASET/RAMWR command stream followed by N pixels as 9-bit command/data words.
- Sits beside lcd_show_char, upstream of muxcontrol/lcd_write, and uses the same en_write/wr_done handshake.
- Used for screen clear and for status-bar backgrounds after init_done.

Parameters:
- OFFSET_X, 8'd2, panel column offset added to x0/x1 before CASET.
- OFFSET_Y, 8'd3, panel row offset added to y0/y1 before RASET.
- WIDTH, 8'd128, visible columns (used only by the optional feature).
- HEIGHT, 8'd128, visible rows (used only by the optional feature).

Ports:
- sys_clk  in  1  system clock (12 MHz board clock).
- sys_rst_n  in  1  reset, asynchronous, active-low.
- fill_start  in  1  one-cycle request; sampled only in IDLE.
- x0, y0, x1, y1  in  8 each  window corners, inclusive.
- colour  in  16  RGB565 fill colour.
- wr_done  in  1  one-cycle pulse from lcd_write: current word has been shifted out.
- fill_data  out  9  bit8 = dc (0 command, 1 data), bits[7:0] = byte.
- en_write_fill  out  1  one-cycle write strobe to lcd_write (via muxcontrol).
- fill_busy  out  1  high from the accepted start until fill_done.
- fill_done  out  1  one-cycle completion pulse.

Behaviour:
- Interface: one clock (sys_clk); reset is asynchronous and active-low (sys_rst_n).
- Reset values:
  - fill_data = 9'h000; en_write_fill, fill_busy, fill_done = 0.
  - FSM = IDLE; counters = 0.
- IDLE:
  - fill_start=1 latches x0..y1 and colour into registers.
  - Each axis is normalised: xs = min(x0,x1), xe = max(x0,x1); same for y.
  - fill_busy rises the next cycle. fill_start while busy is ignored.
- Command sequence, one word per handshake:
  - CMD_CASET 9'h02A, then data 0x00, xs+OFFSET_X, 0x00, xe+OFFSET_X.
  - CMD_RASET 9'h02B, then data 0x00, ys+OFFSET_Y, 0x00, ye+OFFSET_Y.
  - CMD_RAMWR 9'h02C.
  - Offset additions are 8-bit and wrap modulo 256. No saturation.
- Handshake:
  - en_write_fill pulses for exactly one cycle with fill_data valid that cycle.
  - fill_data holds stable until wr_done.
  - The next strobe is issued the cycle after wr_done (1-cycle gap minimum).
  - wr_done arriving while no write is pending is ignored.
- FSM states:
  - IDLE → LATCH → SEND → WAIT → (SEND | PIX_HI | PIX_LO) → DONE → IDLE.
  - A 4-bit index selects the 11 command/data bytes.
- Pixel phase:
  - N = (xe-xs+1)*(ye-ys+1), 15-bit unsigned product (max 16384 at 128x128; 17 bits allowed for the 256x256 worst case).
  - Each pixel sends colour[15:8] then colour[7:0] with dc=1.
  - Pixel counter decrements after the low byte.
  - Total words = 11 + 2N. A single pixel (x0=x1, y0=y1) gives N=1 and 13 words.
- DONE:
  - fill_done pulses one cycle after the final wr_done.
  - fill_busy falls in the same cycle.
  - A new fill_start is accepted from the cycle after DONE.
- Reset mid-operation:
  - Immediate return to IDLE; en_write_fill drops asynchronously.
  - No partial-state recovery; the caller must re-issue the fill.
- Colour and coordinates are sampled only at start. Input changes during busy have no effect.

Optional Feature:
- FILL_CLIP_EN defined:
  - After normalisation, xe is clamped to WIDTH-1 and ye to HEIGHT-1.
  - If xs ≥ WIDTH or ys ≥ HEIGHT, no words are sent; fill_done pulses 2 cycles after start.
- Not defined: coordinates pass through unclipped (8-bit wrap rules above).

Decomposition:
- Shared package lcd_pkg:
  - Constants CMD_CASET/CMD_RASET/CMD_RAMWR (9-bit, dc=0).
  - DC_CMD/DC_DATA.
  - RGB565 colour constants (BLACK 16'h0000, WHITE 16'hFFFF).
  - Used by lcd_show_char as well.
- One natural sub-module: lcd_fill_seq_rom, a combinational index→9-bit word table for the 11 header words.
- The pixel counter and FSM stay in lcd_fill_rect.

Test Plan:
- Window (0,0)-(0,0), colour 16'hF800 → words 02A,100,102,100,102,02B,100,103,100,103,02C,1F8,100. fill_done after the 13th wr_done.
- Window (10,20)-(5,4) with offsets 2/3 → CASET data 07,0C; RASET data 07,17. N = 6*17 = 102, total 215 strobes.
- Full screen (0,0)-(127,127), colour 16'h0000 → 16384 pixels, 32779 strobes. fill_busy stays high throughout; exactly one fill_done.
- fill_start pulsed while busy, and wr_done injected during IDLE → no extra strobes, sequence unchanged.
- sys_rst_n low during the pixel phase → en_write_fill=0 and fill_busy=0 immediately. After release, a new fill runs from CASET.
- FILL_CLIP_EN, window (120,120)-(200,130) → CASET end = 127+2, RASET end = 127+3, N=64. Window (130,0)-(140,5) → zero strobes, fill_done 2 cycles after start.

Source files
------------

// File: rtl/lcd_pkg.sv
// ----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the ST7735 drawing engines (lcd_fill_rect,
// lcd_show_char): 9-bit command words (bit8 = dc), dc values, common RGB565
// colours and the fill engine's state/wait-kind enumerations.
// ----------------------------------------------------------------------------
package lcd_pkg;

   localparam logic DC_CMD  = 1'b0;
   localparam logic DC_DATA = 1'b1;

   localparam logic [8:0] CMD_CASET = {DC_CMD, 8'h2A};
   localparam logic [8:0] CMD_RASET = {DC_CMD, 8'h2B};
   localparam logic [8:0] CMD_RAMWR = {DC_CMD, 8'h2C};

   localparam logic [15:0] BLACK = 16'h0000;
   localparam logic [15:0] WHITE = 16'hFFFF;

   // Index of the last header word (CASET..RAMWR is 11 words, 0..10).
   localparam logic [3:0] HDR_LAST_IDX = 4'd10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LATCH,
      ST_SEND,
      ST_WAIT,
      ST_PIX_HI,
      ST_PIX_LO,
      ST_DONE
   } fill_state_t;

   // What the word currently waiting for wr_done was, so WAIT knows where
   // to go next.
   typedef enum logic [1:0] {
      WK_HDR,
      WK_PIX_HI,
      WK_PIX_LO
   } wait_kind_t;

   function automatic logic [8:0] data_word(input logic [7:0] b);
      return {DC_DATA, b};
   endfunction

endpackage

// File: rtl/lcd_fill_seq_rom.sv
// ----------------------------------------------------------------------------
// lcd_fill_seq_rom
// Combinational table of the 11 header words sent before the pixel stream:
//   0 CASET, 1..4 data 00/xs/00/xe, 5 RASET, 6..9 data 00/ys/00/ye, 10 RAMWR.
// Ports:
//   idx      in  4  header word index (0..10; others give 9'h000)
//   xs_byte  in  8  start column, offset already applied
//   xe_byte  in  8  end column, offset already applied
//   ys_byte  in  8  start row, offset already applied
//   ye_byte  in  8  end row, offset already applied
//   word     out 9  {dc, byte}
// ----------------------------------------------------------------------------
module lcd_fill_seq_rom
   import lcd_pkg::*;
(
   input  logic [3:0] idx,
   input  logic [7:0] xs_byte,
   input  logic [7:0] xe_byte,
   input  logic [7:0] ys_byte,
   input  logic [7:0] ye_byte,
   output logic [8:0] word
);

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no
      // path leaves it unassigned, which would infer a latch.
      word = 9'h000;
      case (idx)
         4'd0:    word = CMD_CASET;
         4'd1:    word = data_word(8'h00);
         4'd2:    word = data_word(xs_byte);
         4'd3:    word = data_word(8'h00);
         4'd4:    word = data_word(xe_byte);
         4'd5:    word = CMD_RASET;
         4'd6:    word = data_word(8'h00);
         4'd7:    word = data_word(ys_byte);
         4'd8:    word = data_word(8'h00);
         4'd9:    word = data_word(ye_byte);
         4'd10:   word = CMD_RAMWR;
         default: word = 9'h000;
      endcase
   end

endmodule

// File: rtl/lcd_fill_rect.sv
// ----------------------------------------------------------------------------
// lcd_fill_rect
// Rectangle-fill engine for the ST7735 128x128 panel. On fill_start it
// captures the window and colour, normalises each axis, then streams
// CASET/RASET/RAMWR plus N = w*h RGB565 pixels (high byte then low byte) as
// 9-bit {dc, byte} words over the en_write/wr_done handshake of lcd_write.
//
// Optional build macro: FILL_CLIP_EN -- clamp the window end to WIDTH-1 /
// HEIGHT-1 and skip the whole transfer when the window starts off-panel.
//
// Ports:
//   sys_clk        in   1  system clock
//   sys_rst_n      in   1  asynchronous active-low reset
//   fill_start     in   1  one-cycle request, sampled only while idle
//   x0,y0,x1,y1    in   8  window corners, inclusive, any order
//   colour         in  16  RGB565 fill colour
//   wr_done        in   1  lcd_write finished the current word
//   fill_data      out  9  {dc, byte}, held until wr_done
//   en_write_fill  out  1  one-cycle write strobe
//   fill_busy      out  1  high from accepted start until fill_done
//   fill_done      out  1  one-cycle completion pulse
// ----------------------------------------------------------------------------
module lcd_fill_rect
   import lcd_pkg::*;
#(
   parameter logic [7:0] OFFSET_X = 8'd2,
   parameter logic [7:0] OFFSET_Y = 8'd3,
   parameter logic [7:0] WIDTH    = 8'd128,
   parameter logic [7:0] HEIGHT   = 8'd128
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        fill_start,
   input  logic [7:0]  x0,
   input  logic [7:0]  y0,
   input  logic [7:0]  x1,
   input  logic [7:0]  y1,
   input  logic [15:0] colour,
   input  logic        wr_done,
   output logic [8:0]  fill_data,
   output logic        en_write_fill,
   output logic        fill_busy,
   output logic        fill_done
);

`ifdef FILL_CLIP_EN
   localparam logic CLIP_EN = 1'b1;
`else
   localparam logic CLIP_EN = 1'b0;
`endif

   fill_state_t state_q, state_d;
   wait_kind_t  kind_q,  kind_d;
   logic [3:0]  idx_q,   idx_d;
   logic [16:0] pix_cnt_q, pix_cnt_d;

   // Raw request, captured in IDLE.
   logic [7:0]  x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
   logic [15:0] colour_q, colour_d;

   // Normalised (and possibly clipped) window, captured in LATCH.
   logic [7:0]  xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;

   logic [8:0]  fill_data_q, fill_data_d;
   logic        en_q, en_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   // Normalisation of the captured corners.
   logic [7:0]  xs_n, xe_n, ys_n, ye_n;
   logic [8:0]  w_n, h_n;
   logic [16:0] pix_n;
   logic        skip_n;

   logic [8:0]  rom_word;

   always_comb begin
      xs_n   = (x0_q < x1_q) ? x0_q : x1_q;
      xe_n   = (x0_q < x1_q) ? x1_q : x0_q;
      ys_n   = (y0_q < y1_q) ? y0_q : y1_q;
      ye_n   = (y0_q < y1_q) ? y1_q : y0_q;
      skip_n = 1'b0;
      if (CLIP_EN) begin
         if (xe_n >= WIDTH)  xe_n = WIDTH  - 8'd1;
         if (ye_n >= HEIGHT) ye_n = HEIGHT - 8'd1;
         skip_n = (xs_n >= WIDTH) || (ys_n >= HEIGHT);
      end
      // 9-bit spans so a 256-wide axis does not wrap to zero.
      w_n   = {1'b0, xe_n} - {1'b0, xs_n} + 9'd1;
      h_n   = {1'b0, ye_n} - {1'b0, ys_n} + 9'd1;
      pix_n = 17'(w_n) * 17'(h_n);
   end

   // The ROM is addressed with the next index so fill_data can be registered
   // together with the strobe. Offset additions wrap modulo 256.
   lcd_fill_seq_rom u_seq_rom (
      .idx     (idx_d),
      .xs_byte (xs_q + OFFSET_X),
      .xe_byte (xe_q + OFFSET_X),
      .ys_byte (ys_q + OFFSET_Y),
      .ye_byte (ye_q + OFFSET_Y),
      .word    (rom_word)
   );

   always_comb begin
      state_d   = state_q;
      kind_d    = kind_q;
      idx_d     = idx_q;
      pix_cnt_d = pix_cnt_q;
      x0_d      = x0_q;
      y0_d      = y0_q;
      x1_d      = x1_q;
      y1_d      = y1_q;
      colour_d  = colour_q;
      xs_d      = xs_q;
      xe_d      = xe_q;
      ys_d      = ys_q;
      ye_d      = ye_q;

      case (state_q)
         ST_IDLE: begin
            if (fill_start) begin
               x0_d     = x0;
               y0_d     = y0;
               x1_d     = x1;
               y1_d     = y1;
               colour_d = colour;
               state_d  = ST_LATCH;
            end
         end
         ST_LATCH: begin
            xs_d      = xs_n;
            xe_d      = xe_n;
            ys_d      = ys_n;
            ye_d      = ye_n;
            pix_cnt_d = pix_n;
            idx_d     = 4'd0;
            kind_d    = WK_HDR;
            state_d   = skip_n ? ST_DONE : ST_SEND;
         end
         ST_SEND:   state_d = ST_WAIT;
         ST_PIX_HI: state_d = ST_WAIT;
         ST_PIX_LO: state_d = ST_WAIT;
         ST_WAIT: begin
            if (wr_done) begin
               case (kind_q)
                  WK_HDR: begin
                     if (idx_q == HDR_LAST_IDX) begin
                        kind_d  = WK_PIX_HI;
                        state_d = ST_PIX_HI;
                     end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = ST_SEND;
                     end
                  end
                  WK_PIX_HI: begin
                     kind_d  = WK_PIX_LO;
                     state_d = ST_PIX_LO;
                  end
                  default: begin
                     // A pixel is complete only once its low byte is out.
                     pix_cnt_d = pix_cnt_q - 17'd1;
                     if (pix_cnt_q == 17'd1) begin
                        state_d = ST_DONE;
                     end else begin
                        kind_d  = WK_PIX_HI;
                        state_d = ST_PIX_HI;
                     end
                  end
               endcase
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Registered outputs follow the next state, so the strobe and its word
   // appear in the same cycle the FSM sits in a send state.
   always_comb begin
      en_d        = (state_d == ST_SEND) || (state_d == ST_PIX_HI) ||
                    (state_d == ST_PIX_LO);
      busy_d      = (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_d      = (state_d == ST_DONE);
      fill_data_d = fill_data_q;
      case (state_d)
         ST_SEND:   fill_data_d = rom_word;
         ST_PIX_HI: fill_data_d = data_word(colour_q[15:8]);
         ST_PIX_LO: fill_data_d = data_word(colour_q[7:0]);
         default:   fill_data_d = fill_data_q;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= ST_IDLE;
         kind_q      <= WK_HDR;
         idx_q       <= 4'd0;
         pix_cnt_q   <= 17'd0;
         x0_q        <= 8'd0;
         y0_q        <= 8'd0;
         x1_q        <= 8'd0;
         y1_q        <= 8'd0;
         colour_q    <= 16'd0;
         xs_q        <= 8'd0;
         xe_q        <= 8'd0;
         ys_q        <= 8'd0;
         ye_q        <= 8'd0;
         fill_data_q <= 9'h000;
         en_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         state_q     <= state_d;
         kind_q      <= kind_d;
         idx_q       <= idx_d;
         pix_cnt_q   <= pix_cnt_d;
         x0_q        <= x0_d;
         y0_q        <= y0_d;
         x1_q        <= x1_d;
         y1_q        <= y1_d;
         colour_q    <= colour_d;
         xs_q        <= xs_d;
         xe_q        <= xe_d;
         ys_q        <= ys_d;
         ye_q        <= ye_d;
         fill_data_q <= fill_data_d;
         en_q        <= en_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign fill_data     = fill_data_q;
   assign en_write_fill = en_q;
   assign fill_busy     = busy_q;
   assign fill_done     = done_q;

endmodule

// File: tb/tb_lcd_fill_rect.sv
// ----------------------------------------------------------------------------
// tb_lcd_fill_rect
// Directed bench for lcd_fill_rect. A combined lcd_write model / monitor
// acknowledges each strobe two cycles later, records the word stream and
// counts protocol, gap and busy anomalies; each test task compares the
// recorded stream against hand-computed words.
// ----------------------------------------------------------------------------
module tb_lcd_fill_rect;
   import lcd_pkg::*;

   localparam int ACK_LAT = 2;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic        fill_start;
   logic [7:0]  x0, y0, x1, y1;
   logic [15:0] colour;
   logic        wr_done;
   logic [8:0]  fill_data;
   logic        en_write_fill;
   logic        fill_busy;
   logic        fill_done;

   lcd_fill_rect dut (
      .sys_clk       (sys_clk),
      .sys_rst_n     (sys_rst_n),
      .fill_start    (fill_start),
      .x0            (x0),
      .y0            (y0),
      .x1            (x1),
      .y1            (y1),
      .colour        (colour),
      .wr_done       (wr_done),
      .fill_data     (fill_data),
      .en_write_fill (en_write_fill),
      .fill_busy     (fill_busy),
      .fill_done     (fill_done)
   );

   always #5 sys_clk = ~sys_clk;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [8:0] words[$];
   logic [8:0] held_word;
   int  cyc = 0, ack_set_cyc = 0, done_cyc = 0, done_cnt = 0;
   int  proto_err = 0, gap_err = 0, busy_err = 0, ack_timer = 0;
   bit  pending = 1'b0, track_busy = 1'b0, inject_ack = 1'b0;

   // lcd_write model and stream monitor, all on the falling edge.
   initial begin
      wr_done = 1'b0;
      forever begin
         @(negedge sys_clk);
         cyc++;
         if (wr_done) begin
            wr_done = 1'b0;
            pending = 1'b0;
         end
         if (!sys_rst_n) begin
            pending   = 1'b0;
            ack_timer = 0;
         end else begin
            if (en_write_fill) begin
               if (pending) proto_err++;
               if (words.size() != 0 && (cyc - ack_set_cyc) != 1) gap_err++;
               words.push_back(fill_data);
               held_word = fill_data;
               pending   = 1'b1;
               ack_timer = ACK_LAT;
            end else if (pending && fill_data !== held_word) begin
               proto_err++;
            end
            if (track_busy) begin
               if (fill_done) begin
                  if (fill_busy) busy_err++;
                  track_busy = 1'b0;
               end else if (!fill_busy) begin
                  busy_err++;
               end
            end
            if (fill_done) begin
               done_cnt++;
               done_cyc = cyc;
            end
            if (inject_ack) begin
               wr_done    = 1'b1;
               inject_ack = 1'b0;
            end else if (pending && ack_timer > 0) begin
               ack_timer--;
               if (ack_timer == 0) begin
                  wr_done     = 1'b1;
                  ack_set_cyc = cyc;
               end
            end
         end
      end
   end

   task automatic start_fill(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d,
                             input logic [15:0] col);
      @(negedge sys_clk);
      words.delete();
      done_cnt  = 0;
      proto_err = 0;
      gap_err   = 0;
      busy_err  = 0;
      x0 = a; y0 = b; x1 = c; y1 = d; colour = col;
      fill_start = 1'b1;
      @(negedge sys_clk);
      fill_start = 1'b0;
      track_busy = 1'b1;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         @(negedge sys_clk);
         n++;
      end
      ok = (done_cnt != 0);
      repeat (8) @(negedge sys_clk);
   endtask

   task automatic test_reset();
      sys_rst_n  = 1'b0;
      fill_start = 1'b0;
      x0 = 8'd0; y0 = 8'd0; x1 = 8'd0; y1 = 8'd0; colour = 16'h0000;
      repeat (3) @(negedge sys_clk);
      total_cnt++;
      if ({fill_data, en_write_fill, fill_busy, fill_done} !== 12'h000)
         $display("FAIL reset_outputs: data=%h en=%b busy=%b done=%b, required all 0",
                  fill_data, en_write_fill, fill_busy, fill_done);
      else pass_cnt++;
      sys_rst_n = 1'b1;
      repeat (2) @(negedge sys_clk);
   endtask

   task automatic test_single_pixel();
      logic [8:0] exp_w[13] = '{9'h02A, 9'h100, 9'h102, 9'h100, 9'h102, 9'h02B,
                                9'h100, 9'h103, 9'h100, 9'h103, 9'h02C, 9'h1F8,
                                9'h100};
      bit ok;
      start_fill(8'd0, 8'd0, 8'd0, 8'd0, 16'hF800);
      wait_done(200, ok);
      total_cnt++;
      if (!ok || words.size() != 13)
         $display("FAIL single_count: done=%0d words=%0d, required 13 words", ok, words.size());
      else pass_cnt++;
      for (int i = 0; i < 13; i++) begin
         total_cnt++;
         if (i >= words.size() || words[i] !== exp_w[i])
            $display("FAIL single_word%0d: got %h, required %h", i,
                     (i < words.size()) ? words[i] : 9'h1FF, exp_w[i]);
         else pass_cnt++;
      end
      total_cnt++;
      if (done_cnt != 1 || done_cyc - ack_set_cyc != 1)
         $display("FAIL single_done_timing: pulses=%0d gap=%0d, required 1 and 1",
                  done_cnt, done_cyc - ack_set_cyc);
      else pass_cnt++;
      total_cnt++;
      if (proto_err != 0 || gap_err != 0 || busy_err != 0)
         $display("FAIL single_protocol: proto=%0d gap=%0d busy=%0d, required 0",
                  proto_err, gap_err, busy_err);
      else pass_cnt++;
   endtask

   task automatic test_swapped_window();
      bit ok;
      start_fill(8'd10, 8'd20, 8'd5, 8'd4, 16'h07E0);
      wait_done(1000, ok);
      total_cnt++;
      if (!ok || words.size() != 215)
         $display("FAIL swap_count: done=%0d words=%0d, required 215", ok, words.size());
      else pass_cnt++;
      total_cnt++;
      if (words.size() != 215 ||
          {words[2], words[4], words[7], words[9]} !== {9'h107, 9'h10C, 9'h107, 9'h117})
         $display("FAIL swap_coords: got %h %h %h %h, required 107 10c 107 117",
                  words[2], words[4], words[7], words[9]);
      else pass_cnt++;
      total_cnt++;
      if (words.size() != 215 ||
          {words[11], words[12], words[214]} !== {9'h107, 9'h1E0, 9'h1E0})
         $display("FAIL swap_pixels: got %h %h %h, required 107 1e0 1e0",
                  words[11], words[12], words[214]);
      else pass_cnt++;
      total_cnt++;
      if (done_cnt != 1 || proto_err != 0 || gap_err != 0 || busy_err != 0)
         $display("FAIL swap_protocol: done=%0d proto=%0d gap=%0d busy=%0d, required 1/0/0/0",
                  done_cnt, proto_err, gap_err, busy_err);
      else pass_cnt++;
   endtask

   task automatic test_full_screen();
      logic [8:0] exp_h[11] = '{9'h02A, 9'h100, 9'h102, 9'h100, 9'h181, 9'h02B,
                                9'h100, 9'h103, 9'h100, 9'h182, 9'h02C};
      int bad = 0;
      bit ok;
      start_fill(8'd0, 8'd0, 8'd127, 8'd127, BLACK);
      wait_done(70000, ok);
      total_cnt++;
      if (!ok || words.size() != 32779)
         $display("FAIL full_count: done=%0d words=%0d, required 32779", ok, words.size());
      else pass_cnt++;
      for (int i = 0; i < words.size(); i++)
         if (words[i] !== ((i < 11) ? exp_h[i] : 9'h100)) bad++;
      total_cnt++;
      if (bad != 0)
         $display("FAIL full_words: %0d wrong words, required 0", bad);
      else pass_cnt++;
      total_cnt++;
      if (done_cnt != 1 || busy_err != 0 || gap_err != 0 || proto_err != 0)
         $display("FAIL full_protocol: done=%0d busy=%0d gap=%0d proto=%0d, required 1/0/0/0",
                  done_cnt, busy_err, gap_err, proto_err);
      else pass_cnt++;
   endtask

   task automatic test_ignored_inputs();
      logic [8:0] exp_w[17] = '{9'h02A, 9'h100, 9'h105, 9'h100, 9'h107, 9'h02B,
                                9'h100, 9'h104, 9'h100, 9'h104, 9'h02C, 9'h112,
                                9'h134, 9'h112, 9'h134, 9'h112, 9'h134};
      int bad = 0;
      bit ok;
      // Stray acknowledge while idle must not create a strobe.
      words.delete();
      @(negedge sys_clk);
      inject_ack = 1'b1;
      repeat (4) @(negedge sys_clk);
      total_cnt++;
      if (words.size() != 0 || fill_busy !== 1'b0)
         $display("FAIL idle_ack: words=%0d busy=%b, required 0 and 0", words.size(), fill_busy);
      else pass_cnt++;
      start_fill(8'd3, 8'd1, 8'd5, 8'd1, 16'h1234);
      // Retrigger with different values while busy; inputs must be ignored.
      for (int k = 0; k < 3; k++) begin
         repeat (5) @(negedge sys_clk);
         x0 = 8'd90; y0 = 8'd90; x1 = 8'd100; y1 = 8'd100; colour = 16'hFFFF;
         fill_start = 1'b1;
         @(negedge sys_clk);
         fill_start = 1'b0;
      end
      wait_done(500, ok);
      total_cnt++;
      if (!ok || words.size() != 17 || done_cnt != 1)
         $display("FAIL busy_count: done=%0d words=%0d pulses=%0d, required 17 and 1",
                  ok, words.size(), done_cnt);
      else pass_cnt++;
      for (int i = 0; i < 17; i++)
         if (i >= words.size() || words[i] !== exp_w[i]) bad++;
      total_cnt++;
      if (bad != 0)
         $display("FAIL busy_words: %0d wrong words, required 0", bad);
      else pass_cnt++;
   endtask

   task automatic test_mid_reset();
      int  n = 0;
      bit  ok;
      start_fill(8'd0, 8'd0, 8'd1, 8'd1, 16'hABCD);
      while (words.size() < 13 && n < 300) begin @(negedge sys_clk); n++; end
      while (!en_write_fill && n < 300) begin @(negedge sys_clk); n++; end
      total_cnt++;
      if (!en_write_fill)
         $display("FAIL reset_reach_pixels: strobe=%b after %0d cycles, required 1", en_write_fill, n);
      else pass_cnt++;
      track_busy = 1'b0;
      #2 sys_rst_n = 1'b0;
      #1;
      total_cnt++;
      if (en_write_fill !== 1'b0 || fill_busy !== 1'b0 || fill_data !== 9'h000)
         $display("FAIL reset_async: en=%b busy=%b data=%h, required 0 0 000",
                  en_write_fill, fill_busy, fill_data);
      else pass_cnt++;
      repeat (5) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (2) @(negedge sys_clk);
      start_fill(8'd2, 8'd2, 8'd2, 8'd2, 16'h0F0F);
      wait_done(200, ok);
      total_cnt++;
      if (!ok || words.size() != 13 || words[0] !== CMD_CASET || words[2] !== 9'h104 ||
          words[12] !== 9'h10F)
         $display("FAIL reset_refill: done=%0d words=%0d w0=%h w2=%h w12=%h, required 13 02a 104 10f",
                  ok, words.size(), words[0], words[2], words[12]);
      else pass_cnt++;
   endtask

`ifdef FILL_CLIP_EN
   task automatic test_clip();
      bit ok;
      start_fill(8'd120, 8'd120, 8'd200, 8'd130, WHITE);
      wait_done(1000, ok);
      total_cnt++;
      if (!ok || words.size() != 139 ||
          {words[2], words[4], words[7], words[9]} !== {9'h17A, 9'h181, 9'h17B, 9'h182})
         $display("FAIL clip_window: words=%0d got %h %h %h %h, required 139 17a 181 17b 182",
                  words.size(), words[2], words[4], words[7], words[9]);
      else pass_cnt++;
      @(negedge sys_clk);
      words.delete();
      x0 = 8'd130; y0 = 8'd0; x1 = 8'd140; y1 = 8'd5; colour = WHITE;
      fill_start = 1'b1;
      @(negedge sys_clk);
      fill_start = 1'b0;
      total_cnt++;
      if (fill_busy !== 1'b1 || fill_done !== 1'b0)
         $display("FAIL clip_skip_c1: busy=%b done=%b, required 1 0", fill_busy, fill_done);
      else pass_cnt++;
      @(negedge sys_clk);
      total_cnt++;
      if (fill_done !== 1'b1 || fill_busy !== 1'b0)
         $display("FAIL clip_skip_c2: done=%b busy=%b, required 1 0", fill_done, fill_busy);
      else pass_cnt++;
      repeat (6) @(negedge sys_clk);
      total_cnt++;
      if (words.size() != 0)
         $display("FAIL clip_skip_words: %0d strobes, required 0", words.size());
      else pass_cnt++;
   endtask
`else
   task automatic test_wrap();
      bit ok;
      start_fill(8'd250, 8'd0, 8'd255, 8'd0, 16'h5A5A);
      wait_done(500, ok);
      total_cnt++;
      if (!ok || words.size() != 23 ||
          {words[2], words[4], words[7], words[9]} !== {9'h1FC, 9'h101, 9'h103, 9'h103})
         $display("FAIL wrap_window: words=%0d got %h %h %h %h, required 23 1fc 101 103 103",
                  words.size(), words[2], words[4], words[7], words[9]);
      else pass_cnt++;
   endtask
`endif

   initial begin
      test_reset();
      test_single_pixel();
      test_swapped_window();
      test_ignored_inputs();
      test_mid_reset();
`ifdef FILL_CLIP_EN
      test_clip();
`else
      test_wrap();
`endif
      test_full_screen();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
